// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: sequences PLL power-down/reset/lock and applies validated dynamic reconfiguration requests.
module pll_reconfig_ctrl #(
  parameter int PWD_CYCLES   = 4,
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int MAX_RETRY    = 2,
  parameter int DEF_IDIV     = 2,
  parameter int DEF_FDIV     = 32,
  parameter int DEF_ODIV0    = 100,
  parameter int DEF_DUTY0    = 100,
  parameter int DEF_PHASE0   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [9:0]  cfg_idiv,
  input  logic [9:0]  cfg_fdiv,
  input  logic [9:0]  cfg_odiv0,
  input  logic [9:0]  cfg_duty0,
  input  logic [12:0] cfg_phase0,
  output logic        cfg_ack,
  output logic        cfg_bad,
  output logic [9:0]  dyn_idiv,
  output logic [9:0]  dyn_fdiv,
  output logic [9:0]  dyn_odiv0,
  output logic [9:0]  dyn_duty0,
  output logic [12:0] dyn_phase0,
  output logic        pll_pwd,
  output logic        pll_rst,
  input  logic        pll_lock,
  output logic        locked,
  output logic        busy,
  output logic        done,
  output logic        lock_lost,
  output logic        err
);
  localparam int CMAX = PWD_CYCLES > RST_CYCLES ? PWD_CYCLES : RST_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam int SW = $clog2(LOCK_STABLE) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int RW = $clog2(MAX_RETRY) + 1;
  typedef enum logic [2:0] {PWD, RST, WAIT_LOCK, RUN, ERROR} state_t;
  state_t state_q, state_d;
  logic lk_meta_q, lk_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic locked_q, locked_d, ack_q, ack_d, bad_q, bad_d, done_q, done_d, lost_q, lost_d;
  logic [9:0] idiv_q, idiv_d, fdiv_q, fdiv_d, odiv_q, odiv_d, duty_q, duty_d;
  logic [12:0] phase_q, phase_d;
  logic take, valid;
  always_ff @(posedge clk) begin
    lk_meta_q <= pll_lock;
    lk_q      <= lk_meta_q;
    if (rst) begin
      state_q  <= PWD;
      cnt_q    <= '0;
      stable_q <= '0;
      tmo_q    <= '0;
      retry_q  <= '0;
      locked_q <= 1'b0;
      ack_q    <= 1'b0;
      bad_q    <= 1'b0;
      done_q   <= 1'b0;
      lost_q   <= 1'b0;
      idiv_q   <= 10'(DEF_IDIV);
      fdiv_q   <= 10'(DEF_FDIV);
      odiv_q   <= 10'(DEF_ODIV0);
      duty_q   <= 10'(DEF_DUTY0);
      phase_q  <= 13'(DEF_PHASE0);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      locked_q <= locked_d;
      ack_q    <= ack_d;
      bad_q    <= bad_d;
      done_q   <= done_d;
      lost_q   <= lost_d;
      idiv_q   <= idiv_d;
      fdiv_q   <= fdiv_d;
      odiv_q   <= odiv_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
    end
  end
  // ack_q masks the still-held request in the cycle the requester sees the ack
  assign take  = cfg_req && !ack_q && (state_q == RUN || state_q == ERROR);
  assign valid = |cfg_idiv && |cfg_fdiv && |cfg_odiv0;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    locked_d = locked_q;
    ack_d    = 1'b0;
    bad_d    = 1'b0;
    done_d   = 1'b0;
    lost_d   = 1'b0;
    idiv_d   = idiv_q;
    fdiv_d   = fdiv_q;
    odiv_d   = odiv_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    case (state_q)
      PWD: begin
        cnt_d = cnt_q + 1'b1;
        if (int'(cnt_q) >= PWD_CYCLES - 1) begin
          state_d = RST;
          cnt_d   = '0;
        end
      end
      RST: begin
        cnt_d = cnt_q + 1'b1;
        if (int'(cnt_q) >= RST_CYCLES - 1) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          stable_d = '0;
          tmo_d    = '0;
        end
      end
      WAIT_LOCK: begin
        stable_d = lk_q ? (int'(stable_q) < LOCK_STABLE ? stable_q + 1'b1 : stable_q) : '0;
        tmo_d    = int'(tmo_q) < LOCK_TIMEOUT ? tmo_q + 1'b1 : tmo_q;
        if (lk_q && int'(stable_q) >= LOCK_STABLE - 1) begin
          state_d  = RUN;
          locked_d = 1'b1;
          done_d   = 1'b1;
        end else if (int'(tmo_q) >= LOCK_TIMEOUT - 1) begin
          if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + 1'b1;
            state_d = RST;
            cnt_d   = '0;
          end else begin
            state_d = ERROR;
          end
        end
      end
      RUN: begin
        if (!lk_q) begin
          locked_d = 1'b0;
          lost_d   = 1'b1;
          retry_d  = '0;
          state_d  = RST;
          cnt_d    = '0;
        end
      end
      default: ;
    endcase
    if (take) begin
      ack_d = 1'b1;
      bad_d = !valid;
      if (valid) begin
        idiv_d   = cfg_idiv;
        fdiv_d   = cfg_fdiv;
        odiv_d   = cfg_odiv0;
        duty_d   = cfg_duty0;
        phase_d  = cfg_phase0;
        retry_d  = '0;
        locked_d = 1'b0;
        state_d  = PWD;
        cnt_d    = '0;
      end
    end
  end
  assign pll_pwd    = rst || state_q == PWD;
  assign pll_rst    = rst || state_q == RST;
  assign busy       = rst || !(state_q == RUN || state_q == ERROR);
  assign err        = !rst && state_q == ERROR;
  assign locked     = !rst && locked_q;
  assign done       = !rst && done_q;
  assign lock_lost  = !rst && lost_q;
  assign cfg_ack    = !rst && ack_q;
  assign cfg_bad    = !rst && bad_q;
  assign dyn_idiv   = rst ? 10'(DEF_IDIV) : idiv_q;
  assign dyn_fdiv   = rst ? 10'(DEF_FDIV) : fdiv_q;
  assign dyn_odiv0  = rst ? 10'(DEF_ODIV0) : odiv_q;
  assign dyn_duty0  = rst ? 10'(DEF_DUTY0) : duty_q;
  assign dyn_phase0 = rst ? 13'(DEF_PHASE0) : phase_q;
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: directed scenario tests of pll_reconfig_ctrl with default parameters.
module tb_pll_reconfig_ctrl;
  logic clk = 1'b0, rst = 1'b1, cfg_req = 1'b0, pll_lock = 1'b0;
  logic [9:0] cfg_idiv = 10'd2, cfg_fdiv = 10'd32, cfg_odiv0 = 10'd100, cfg_duty0 = 10'd100;
  logic [12:0] cfg_phase0 = 13'd16;
  logic cfg_ack, cfg_bad, pll_pwd, pll_rst, locked, busy, done, lock_lost, err;
  logic [9:0] dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_duty0;
  logic [12:0] dyn_phase0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  pll_reconfig_ctrl dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_idiv(cfg_idiv), .cfg_fdiv(cfg_fdiv),
    .cfg_odiv0(cfg_odiv0), .cfg_duty0(cfg_duty0), .cfg_phase0(cfg_phase0),
    .cfg_ack(cfg_ack), .cfg_bad(cfg_bad), .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv),
    .dyn_odiv0(dyn_odiv0), .dyn_duty0(dyn_duty0), .dyn_phase0(dyn_phase0),
    .pll_pwd(pll_pwd), .pll_rst(pll_rst), .pll_lock(pll_lock), .locked(locked),
    .busy(busy), .done(done), .lock_lost(lock_lost), .err(err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_lock(output int n);
    n = 0;
    while (!locked && n < 400) begin
      tick();
      n++;
    end
  endtask
  task automatic req(input logic [9:0] i, input logic [9:0] f, input logic [9:0] o, input logic [9:0] d);
    cfg_idiv = i;
    cfg_fdiv = f;
    cfg_odiv0 = o;
    cfg_duty0 = d;
    cfg_phase0 = 13'd16;
    cfg_req = 1'b1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if ({pll_pwd, pll_rst, busy} !== 3'b111) begin n_bad++; $display("FAIL reset_ctl: got %b want 111", {pll_pwd, pll_rst, busy}); end
    n_cmp++; if ({locked, done, lock_lost, err, cfg_ack, cfg_bad} !== 6'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 000000", {locked, done, lock_lost, err, cfg_ack, cfg_bad}); end
    n_cmp++; if (dyn_idiv !== 10'd2 || dyn_fdiv !== 10'd32 || dyn_odiv0 !== 10'd100 || dyn_duty0 !== 10'd100 || dyn_phase0 !== 13'd16) begin n_bad++; $display("FAIL reset_dyn: got %0d/%0d/%0d/%0d/%0d want 2/32/100/100/16", dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_duty0, dyn_phase0); end
  endtask
  task automatic test_powerup;
    int n;
    rst = 1'b0;
    #1;
    n = 0;
    while (pll_pwd && n < 50) begin tick(); n++; end
    n_cmp++; if (n !== 4 || pll_rst !== 1'b1) begin n_bad++; $display("FAIL pu_pwd_width: got %0d rst=%b want 4 rst=1", n, pll_rst); end
    n = 0;
    while (pll_rst && n < 50) begin tick(); n++; end
    n_cmp++; if (n !== 8 || pll_pwd !== 1'b0) begin n_bad++; $display("FAIL pu_rst_width: got %0d pwd=%b want 8 pwd=0", n, pll_pwd); end
    repeat (50) tick();
    pll_lock = 1'b1;
    wait_lock(n);
    n_cmp++; if (n !== 18 || done !== 1'b1) begin n_bad++; $display("FAIL pu_lock_time: got %0d done=%b want 18 done=1", n, done); end
    n_cmp++; if (dyn_idiv !== 10'd2 || dyn_odiv0 !== 10'd100) begin n_bad++; $display("FAIL pu_dyn: got %0d/%0d want 2/100", dyn_idiv, dyn_odiv0); end
    tick();
    n_cmp++; if ({done, locked, busy} !== 3'b010) begin n_bad++; $display("FAIL pu_run: got %b want 010", {done, locked, busy}); end
  endtask
  task automatic test_cfg;
    int n;
    req(10'd2, 10'd32, 10'd200, 10'd200);
    tick();
    n_cmp++; if ({cfg_ack, cfg_bad, locked, pll_pwd} !== 4'b1001) begin n_bad++; $display("FAIL cfg_ack: got %b want 1001", {cfg_ack, cfg_bad, locked, pll_pwd}); end
    n_cmp++; if (dyn_odiv0 !== 10'd200 || dyn_duty0 !== 10'd200) begin n_bad++; $display("FAIL cfg_dyn: got %0d/%0d want 200/200", dyn_odiv0, dyn_duty0); end
    cfg_req = 1'b0;
    n = 0;
    while (pll_pwd && n < 50) begin tick(); n++; end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL cfg_pwd_width: got %0d want 4", n); end
    n = 0;
    while (pll_rst && n < 50) begin tick(); n++; end
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL cfg_rst_width: got %0d want 8", n); end
    wait_lock(n);
    n_cmp++; if (n !== 16 || done !== 1'b1 || dyn_odiv0 !== 10'd200) begin n_bad++; $display("FAIL cfg_relock: got n=%0d done=%b odiv=%0d want 16/1/200", n, done, dyn_odiv0); end
  endtask
  task automatic test_bad;
    req(10'd0, 10'd32, 10'd50, 10'd50);
    tick();
    n_cmp++; if ({cfg_ack, cfg_bad, locked} !== 3'b111) begin n_bad++; $display("FAIL bad_pulse: got %b want 111", {cfg_ack, cfg_bad, locked}); end
    n_cmp++; if (dyn_idiv !== 10'd2 || dyn_odiv0 !== 10'd200) begin n_bad++; $display("FAIL bad_dyn: got %0d/%0d want 2/200", dyn_idiv, dyn_odiv0); end
    cfg_req = 1'b0;
    tick();
    n_cmp++; if ({cfg_ack, cfg_bad, locked, busy} !== 4'b0010) begin n_bad++; $display("FAIL bad_after: got %b want 0010", {cfg_ack, cfg_bad, locked, busy}); end
  endtask
  task automatic test_lock_loss;
    int n;
    logic saw_pwd;
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 1;
    while (!lock_lost && n < 10) begin tick(); n++; end
    n_cmp++; if (n !== 3 || {locked, pll_rst, pll_pwd} !== 3'b010) begin n_bad++; $display("FAIL loss_pulse: got n=%0d %b want 3 010", n, {locked, pll_rst, pll_pwd}); end
    saw_pwd = 1'b0;
    n = 0;
    while (pll_rst && n < 50) begin saw_pwd |= pll_pwd; tick(); n++; end
    n_cmp++; if (n !== 8 || saw_pwd !== 1'b0) begin n_bad++; $display("FAIL loss_rst: got %0d pwd=%b want 8 pwd=0", n, saw_pwd); end
    wait_lock(n);
    n_cmp++; if (n !== 16 || done !== 1'b1 || dyn_odiv0 !== 10'd200) begin n_bad++; $display("FAIL loss_relock: got n=%0d done=%b odiv=%0d want 16/1/200", n, done, dyn_odiv0); end
  endtask
  task automatic test_req_vs_loss;
    int n;
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    req(10'd2, 10'd32, 10'd150, 10'd150);
    tick();
    n_cmp++; if ({cfg_ack, lock_lost, pll_pwd, pll_rst} !== 4'b1110 || dyn_odiv0 !== 10'd150) begin n_bad++; $display("FAIL race: got %b odiv=%0d want 1110 150", {cfg_ack, lock_lost, pll_pwd, pll_rst}, dyn_odiv0); end
    cfg_req = 1'b0;
    wait_lock(n);
    n_cmp++; if (n !== 28 || done !== 1'b1) begin n_bad++; $display("FAIL race_relock: got %0d done=%b want 28 1", n, done); end
  endtask
  task automatic test_timeout;
    int n, pulses;
    logic prev;
    pll_lock = 1'b0;
    req(10'd2, 10'd32, 10'd100, 10'd100);
    tick();
    cfg_req = 1'b0;
    n = 0;
    pulses = 0;
    prev = 1'b0;
    while (!err && n < 5000) begin
      if (pll_rst && !prev) pulses++;
      prev = pll_rst;
      tick();
      n++;
    end
    n_cmp++; if (n !== 3028 || pulses !== 3) begin n_bad++; $display("FAIL to_time: got %0d cycles %0d attempts want 3028 3", n, pulses); end
    repeat (5) tick();
    n_cmp++; if ({err, busy, pll_pwd, pll_rst, locked} !== 5'b10000) begin n_bad++; $display("FAIL to_err: got %b want 10000", {err, busy, pll_pwd, pll_rst, locked}); end
    pll_lock = 1'b1;
    req(10'd2, 10'd32, 10'd120, 10'd100);
    tick();
    n_cmp++; if ({cfg_ack, err, pll_pwd} !== 3'b101 || dyn_odiv0 !== 10'd120) begin n_bad++; $display("FAIL to_restart: got %b odiv=%0d want 101 120", {cfg_ack, err, pll_pwd}, dyn_odiv0); end
    cfg_req = 1'b0;
    wait_lock(n);
    n_cmp++; if (n !== 28) begin n_bad++; $display("FAIL to_relock: got %0d want 28", n); end
  endtask
  task automatic test_reset_mid;
    int n;
    pll_lock = 1'b0;
    req(10'd2, 10'd32, 10'd200, 10'd100);
    tick();
    n_cmp++; if (cfg_ack !== 1'b1 || dyn_odiv0 !== 10'd200) begin n_bad++; $display("FAIL mid_req: got ack=%b odiv=%0d want 1 200", cfg_ack, dyn_odiv0); end
    cfg_req = 1'b0;
    repeat (20) tick();
    n_cmp++; if ({busy, pll_pwd, pll_rst, locked} !== 4'b1000) begin n_bad++; $display("FAIL mid_wait: got %b want 1000", {busy, pll_pwd, pll_rst, locked}); end
    rst = 1'b1;
    cfg_req = 1'b1;
    #1;
    n_cmp++; if ({pll_pwd, pll_rst, busy} !== 3'b111 || dyn_odiv0 !== 10'd100) begin n_bad++; $display("FAIL mid_rst: got %b odiv=%0d want 111 100", {pll_pwd, pll_rst, busy}, dyn_odiv0); end
    tick();
    tick();
    n_cmp++; if ({cfg_ack, err, locked} !== 3'b000 || dyn_odiv0 !== 10'd100) begin n_bad++; $display("FAIL mid_hold: got %b odiv=%0d want 000 100", {cfg_ack, err, locked}, dyn_odiv0); end
    rst = 1'b0;
    cfg_req = 1'b0;
    pll_lock = 1'b1;
    #1;
    n = 0;
    while (pll_pwd && n < 50) begin tick(); n++; end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL mid_pwd: got %0d want 4", n); end
    n = 0;
    while (pll_rst && n < 50) begin tick(); n++; end
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL mid_rstw: got %0d want 8", n); end
    wait_lock(n);
    n_cmp++; if (n !== 16 || dyn_odiv0 !== 10'd100) begin n_bad++; $display("FAIL mid_lock: got %0d odiv=%0d want 16 100", n, dyn_odiv0); end
  endtask
  initial begin
    test_reset();
    test_powerup();
    test_cfg();
    test_bad();
    test_lock_loss();
    test_req_vs_loss();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PWD_CYCLES, 4: cycles pll_pwd is held high.
- RST_CYCLES, 8: cycles pll_rst is held high.
- LOCK_STABLE, 16: consecutive synchronized-lock cycles required to declare lock.
- LOCK_TIMEOUT, 1000: cycles in WAIT_LOCK before a retry.
- MAX_RETRY, 2: retries after the first attempt before ERROR.
- DEF_IDIV/DEF_FDIV/DEF_ODIV0/DEF_DUTY0/DEF_PHASE0, 2/32/100/100/16: power-up configuration.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock; every flop is clocked by it.
- rst, in, 1: synchronous, active-high reset.
- cfg_req, in, 1: level request to apply a new configuration; held until cfg_ack.
- cfg_idiv/cfg_fdiv/cfg_odiv0/cfg_duty0, in, 10 each: requested dividers and duty.
- cfg_phase0, in, 13: requested phase.
- cfg_ack, out, 1: one-cycle acceptance pulse.
- cfg_bad, out, 1: one-cycle pulse when the request is rejected as invalid.
- dyn_idiv/dyn_fdiv/dyn_odiv0/dyn_duty0, out, 10 each: registered values to the PLL.
- dyn_phase0, out, 13: registered phase to the PLL.
- pll_pwd, out, 1: PLL power-down.
- pll_rst, out, 1: PLL reset.
- pll_lock, in, 1: raw PLL lock, asynchronous to clk.
- locked, out, 1: qualified stable lock.
- busy, out, 1: high in all states except RUN and ERROR.
- done, out, 1: one-cycle pulse when locked rises.
- lock_lost, out, 1: one-cycle pulse on loss of lock in RUN.
- err, out, 1: high while in ERROR.

Function
REQ-003 pll_lock SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value lk.
REQ-004 FSM states SHALL be PWD, RST, WAIT_LOCK, RUN, ERROR.
REQ-005 PWD SHALL drive pll_pwd=1 for exactly PWD_CYCLES cycles, then go to RST.
REQ-006 RST SHALL drive pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK, clearing the stable and timeout counters.
REQ-007 WAIT_LOCK SHALL count consecutive lk=1 cycles and clear the count on any lk=0.
REQ-008 When the stable count reaches LOCK_STABLE, the FSM SHALL go to RUN and set locked=1, with done pulsed in that same cycle.
REQ-009 If the timeout counter reaches LOCK_TIMEOUT first:
- retry<MAX_RETRY: increment retry and go to RST.
- otherwise: go to ERROR.
REQ-010 In RUN or ERROR, a sampled cfg_req SHALL be validated:
- idiv, fdiv and odiv0 all nonzero: next cycle cfg_ack=1, dyn_* load cfg_*, retry=0, locked=0, state=PWD.
- any of them zero: next cycle cfg_ack=1 and cfg_bad=1; dyn_* and state are unchanged.
REQ-011 cfg_req SHALL be ignored (no ack) in PWD, RST and WAIT_LOCK; the requester holds it.
REQ-012 In RUN, lk=0 for one cycle SHALL cause, next cycle: locked=0, lock_lost=1, retry=0, state=RST, with dyn_* unchanged.
REQ-013 If a valid cfg_req and lk=0 coincide in RUN, the request SHALL win (state=PWD, cfg_ack=1), and lock_lost SHALL still pulse.
REQ-014 dyn_* SHALL change only on reset or on an accepted valid request, and SHALL be stable throughout PWD, RST and WAIT_LOCK.
REQ-015 Counters SHALL saturate, not wrap; widths are sized by $clog2 of the respective parameter plus 1.
REQ-016 ERROR SHALL hold err=1, pll_pwd=0 and pll_rst=0 until a valid request is accepted.

Reset
REQ-017 While rst=1, outputs SHALL be: dyn_*=DEF_*, pll_pwd=1, pll_rst=1, and locked, busy-pulses, done, lock_lost, err, cfg_ack and cfg_bad all 0, with busy=1.
REQ-018 On the first cycle after rst falls, the FSM SHALL be in PWD with all counters 0, and SHALL run the full power-up sequence on the defaults.
REQ-019 Reset asserted mid-sequence SHALL abort immediately to the REQ-017 values, and any pending request SHALL be dropped.

Verification
REQ-020 Power-up, pll_lock rising 50 cycles after pll_rst falls:
- pll_pwd high 4 cycles, then pll_rst high 8 cycles.
- locked and done at 50+2+16 cycles into WAIT_LOCK.
- dyn_idiv=2, dyn_odiv0=100.
REQ-021 In RUN, cfg_req with odiv0=200, duty0=200:
- cfg_ack pulses one cycle later, dyn_odiv0=200, and the full PWD/RST/lock sequence repeats.
REQ-022 In RUN, cfg_req with idiv=0 -> cfg_bad=1 and cfg_ack=1 for one cycle; dyn_* unchanged; locked stays 1.
REQ-023 pll_lock held low forever -> 3 attempts of 1000 WAIT_LOCK cycles each, then err=1 and busy=0; a valid cfg_req restarts the sequence.
REQ-024 pll_lock drops for one cycle in RUN -> lock_lost pulse, pll_rst high 8 cycles without pll_pwd, relock, and done pulses again.
REQ-025 rst asserted during WAIT_LOCK after a request to odiv0=200 -> dyn_odiv0 returns to 100 and the sequence restarts from PWD.
